// File: rtl/ws_seq_pkg.sv
// Shared types and instruction encodings for the weight-stationary array sequencer.
package ws_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_LOAD_DRAIN,
        ST_COMPUTE,
        ST_DRAIN,
        ST_DONE
    } state_e;

    localparam logic [1:0] INST_IDLE = 2'b00;
    localparam logic [1:0] INST_LOAD = 2'b01;
    localparam logic [1:0] INST_EXEC = 2'b10;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/seq_counter.sv
// Loadable saturating up-counter with an equality terminal-count flag.
module seq_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             inc,
    input  logic [WIDTH-1:0] terminal,
    output logic             at_term
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (inc && (count_q != '1)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign at_term = (count_q == terminal);

endmodule

// File: rtl/ws_array_sequencer.sv
// Sequencer driving L0 reads and row-0 load/execute instructions for the MAC array.
//   state       | meaning
//   ST_IDLE     | waiting for a start request
//   ST_LOAD     | reading col kernel vectors from L0
//   ST_LOAD_DRAIN | letting load beats ripple through the array
//   ST_COMPUTE  | reading num_nij activation vectors, gated by OFIFO space
//   ST_DRAIN    | letting execute beats reach the OFIFO
//   ST_DONE     | one-cycle completion pulse
module ws_array_sequencer
    import ws_seq_pkg::*;
#(
    parameter int row    = 8,
    parameter int col    = 8,
    parameter int nij_bw = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start_kernel_load,
    input  logic              start_mac_compute,
    input  logic [nij_bw-1:0] num_nij_to_compute,
    input  logic              l0_o_ready,
    input  logic              ofifo_almost_full,
    output logic              l0_rd,
    output logic [1:0]        inst_w,
    output logic              busy,
    output logic              done,
    output logic              kernel_loaded,
    output logic              error
);

    localparam int ISSUE_W = max_int($clog2(col + 1), nij_bw);
    localparam int DRAIN_W = $clog2(row + col);
    localparam logic [ISSUE_W-1:0] COL_TERM   = ISSUE_W'(col - 1);
    localparam logic [DRAIN_W-1:0] DRAIN_TERM = DRAIN_W'(row + col - 1);

    state_e              state_q, state_d;
    logic [nij_bw-1:0]   num_nij_q, num_nij_d;
    logic                kernel_loaded_q, kernel_loaded_d;
    logic                error_q, error_d;
    logic [1:0]          inst_w_q, inst_w_d;

    logic                issue_load, issue_at_term;
    logic [ISSUE_W-1:0]  issue_term;
    logic                drain_load, drain_at_term;

    always_comb begin
        state_d         = state_q;
        num_nij_d       = num_nij_q;
        kernel_loaded_d = kernel_loaded_q;
        error_d         = error_q;
        l0_rd           = 1'b0;
        issue_load      = 1'b0;
        drain_load      = 1'b1;
        done            = 1'b0;
        // Terminal is the last read's index, so the exit happens on the accepting cycle.
        issue_term      = (state_q == ST_LOAD) ? COL_TERM
                                               : ISSUE_W'(num_nij_q) - ISSUE_W'(1);

        case (state_q)
            ST_IDLE: begin
                issue_load = 1'b1;
                if (start_kernel_load) begin
                    state_d         = ST_LOAD;
                    kernel_loaded_d = 1'b0;
                    if (start_mac_compute) begin
                        error_d = 1'b1;
                    end
                end else if (start_mac_compute) begin
                    if (kernel_loaded_q) begin
                        state_d   = ST_COMPUTE;
                        num_nij_d = num_nij_to_compute;
                    end else begin
                        error_d = 1'b1;
                    end
                end
            end
            ST_LOAD: begin
                l0_rd = l0_o_ready;
                if (l0_rd && issue_at_term) begin
                    state_d = ST_LOAD_DRAIN;
                end
            end
            ST_LOAD_DRAIN: begin
                drain_load = 1'b0;
                if (drain_at_term) begin
                    state_d         = ST_DONE;
                    kernel_loaded_d = 1'b1;
                end
            end
            ST_COMPUTE: begin
                if (num_nij_q == '0) begin
                    state_d = ST_DONE;
                end else begin
                    l0_rd = l0_o_ready && !ofifo_almost_full;
                    if (l0_rd && issue_at_term) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                drain_load = 1'b0;
                if (drain_at_term) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if ((state_q != ST_IDLE) && (start_kernel_load || start_mac_compute)) begin
            error_d = 1'b1;
        end

        inst_w_d = INST_IDLE;
        if (l0_rd) begin
            inst_w_d = (state_q == ST_LOAD) ? INST_LOAD : INST_EXEC;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= ST_IDLE;
            num_nij_q       <= '0;
            kernel_loaded_q <= 1'b0;
            error_q         <= 1'b0;
            inst_w_q        <= INST_IDLE;
        end else begin
            state_q         <= state_d;
            num_nij_q       <= num_nij_d;
            kernel_loaded_q <= kernel_loaded_d;
            error_q         <= error_d;
            inst_w_q        <= inst_w_d;
        end
    end

    seq_counter #(.WIDTH(ISSUE_W)) u_issue_cnt (
        .clk      (clk),
        .reset    (reset),
        .load     (issue_load),
        .load_val ('0),
        .inc      (l0_rd),
        .terminal (issue_term),
        .at_term  (issue_at_term)
    );

    seq_counter #(.WIDTH(DRAIN_W)) u_drain_cnt (
        .clk      (clk),
        .reset    (reset),
        .load     (drain_load),
        .load_val ('0),
        .inc      (!drain_load),
        .terminal (DRAIN_TERM),
        .at_term  (drain_at_term)
    );

    assign inst_w        = inst_w_q;
    assign busy          = (state_q != ST_IDLE);
    assign kernel_loaded = kernel_loaded_q;
    assign error         = error_q;

endmodule

// File: tb/tb_ws_array_sequencer.sv
// Directed bench for ws_array_sequencer (row=8, col=8): pass timing, flow control, error cases.
module tb_ws_array_sequencer;
    import ws_seq_pkg::*;

    logic       clk;
    logic       reset;
    logic       start_kernel_load;
    logic       start_mac_compute;
    logic [7:0] num_nij_to_compute;
    logic       l0_o_ready;
    logic       ofifo_almost_full;
    logic       l0_rd;
    logic [1:0] inst_w;
    logic       busy;
    logic       done;
    logic       kernel_loaded;
    logic       error;

    int vectors;
    int miscompares;

    ws_array_sequencer #(.row(8), .col(8), .nij_bw(8)) dut (
        .clk                (clk),
        .reset              (reset),
        .start_kernel_load  (start_kernel_load),
        .start_mac_compute  (start_mac_compute),
        .num_nij_to_compute (num_nij_to_compute),
        .l0_o_ready         (l0_o_ready),
        .ofifo_almost_full  (ofifo_almost_full),
        .l0_rd              (l0_rd),
        .inst_w             (inst_w),
        .busy               (busy),
        .done               (done),
        .kernel_loaded      (kernel_loaded),
        .error              (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Ends at the sampling point: 2 time units after a rising edge.
    task automatic do_reset(input int n);
        reset = 1'b1;
        repeat (n) @(posedge clk);
        #1 reset = 1'b0;
        #1;
    endtask

    // Caller raises the start request beforehand; cycle k is sampled after edge k-1
    // where edge 0 is the one that samples the start.
    task automatic run_pass(input int budget, input logic [1:0] code, input logic [63:0] rdy_low,
                            input int af_lo, input int af_hi, input int inj_cyc,
                            output int done_cyc, output int reads, output int nload,
                            output int nexec, output int viol);
        logic prev_rd;
        prev_rd = 1'b0;
        done_cyc = -1; reads = 0; nload = 0; nexec = 0; viol = 0;
        for (int k = 1; k <= budget; k++) begin
            @(posedge clk);
            #1;
            start_kernel_load = (k == inj_cyc);
            start_mac_compute = 1'b0;
            l0_o_ready        = (k < 64) ? ~rdy_low[k[5:0]] : 1'b1;
            ofifo_almost_full = (k >= af_lo) && (k <= af_hi);
            #1;
            if (l0_rd) reads++;
            if (l0_rd && (ofifo_almost_full || !l0_o_ready)) viol++;
            if (inst_w == INST_LOAD) nload++;
            if (inst_w == INST_EXEC) nexec++;
            if (inst_w !== (prev_rd ? code : INST_IDLE)) viol++;
            if (busy !== 1'b1) viol++;
            prev_rd = l0_rd;
            if (done) begin
                done_cyc = k;
                break;
            end
        end
        start_kernel_load = 1'b0;
        ofifo_almost_full = 1'b0;
    endtask

    task automatic test_reset();
        do_reset(2);
        vectors++; if ({l0_rd, inst_w, busy, done} !== 5'b0) begin miscompares++;
            $display("FAIL reset_outputs: got %b, want 00000", {l0_rd, inst_w, busy, done}); end
        vectors++; if (kernel_loaded !== 1'b0) begin miscompares++;
            $display("FAIL reset_kernel_loaded: got %b, want 0", kernel_loaded); end
        vectors++; if (error !== 1'b0) begin miscompares++;
            $display("FAIL reset_error: got %b, want 0", error); end
    endtask

    task automatic test_compute_before_load();
        int rd_seen;
        rd_seen = 0;
        l0_o_ready = 1'b1;
        num_nij_to_compute = 8'd4;
        start_mac_compute = 1'b1;
        @(posedge clk); #1 start_mac_compute = 1'b0; #1;
        vectors++; if (busy !== 1'b0) begin miscompares++;
            $display("FAIL nokernel_busy: got %b, want 0", busy); end
        vectors++; if (error !== 1'b1) begin miscompares++;
            $display("FAIL nokernel_error: got %b, want 1", error); end
        repeat (3) begin
            @(posedge clk); #2;
            if (l0_rd) rd_seen++;
        end
        vectors++; if (rd_seen !== 0) begin miscompares++;
            $display("FAIL nokernel_reads: got %0d, want 0", rd_seen); end
    endtask

    task automatic test_load();
        int dc, rd, nl, ne, v;
        start_kernel_load = 1'b1;
        run_pass(60, INST_LOAD, 64'h0, 0, -1, 0, dc, rd, nl, ne, v);
        vectors++; if (dc !== 25) begin miscompares++;
            $display("FAIL load_done_cycle: got %0d, want 25", dc); end
        vectors++; if (rd !== 8) begin miscompares++;
            $display("FAIL load_reads: got %0d, want 8", rd); end
        vectors++; if (nl !== 8 || ne !== 0) begin miscompares++;
            $display("FAIL load_beats: got load=%0d exec=%0d, want 8/0", nl, ne); end
        vectors++; if (v !== 0) begin miscompares++;
            $display("FAIL load_protocol: got %0d violations, want 0", v); end
        vectors++; if (kernel_loaded !== 1'b1) begin miscompares++;
            $display("FAIL load_kernel_loaded: got %b, want 1", kernel_loaded); end
        @(posedge clk); #2;
        vectors++; if ({busy, done, error} !== 3'b000) begin miscompares++;
            $display("FAIL load_idle: got busy/done/error=%b, want 000", {busy, done, error}); end
    endtask

    task automatic test_compute();
        int dc, rd, nl, ne, v;
        num_nij_to_compute = 8'd36;
        start_mac_compute = 1'b1;
        run_pass(120, INST_EXEC, 64'h0, 0, -1, 0, dc, rd, nl, ne, v);
        num_nij_to_compute = 8'd0;
        vectors++; if (dc !== 53) begin miscompares++;
            $display("FAIL compute_done_cycle: got %0d, want 53", dc); end
        vectors++; if (rd !== 36 || ne !== 36 || nl !== 0) begin miscompares++;
            $display("FAIL compute_counts: got reads=%0d exec=%0d load=%0d, want 36/36/0", rd, ne, nl); end
        vectors++; if (v !== 0) begin miscompares++;
            $display("FAIL compute_protocol: got %0d violations, want 0", v); end
        @(posedge clk); #2;
        vectors++; if ({busy, kernel_loaded, error} !== 3'b010) begin miscompares++;
            $display("FAIL compute_idle: got busy/kl/error=%b, want 010", {busy, kernel_loaded, error}); end
    endtask

    // Ready low in cycles 3,4,10,17; almost-full in 8..12 -> 8 stall cycles.
    task automatic test_back_pressure();
        int dc, rd, nl, ne, v;
        num_nij_to_compute = 8'd20;
        start_mac_compute = 1'b1;
        run_pass(120, INST_EXEC, 64'h0000_0000_0002_0418, 8, 12, 0, dc, rd, nl, ne, v);
        l0_o_ready = 1'b1;
        vectors++; if (dc !== 45) begin miscompares++;
            $display("FAIL bp_done_cycle: got %0d, want 45", dc); end
        vectors++; if (rd !== 20 || ne !== 20) begin miscompares++;
            $display("FAIL bp_counts: got reads=%0d exec=%0d, want 20/20", rd, ne); end
        vectors++; if (v !== 0) begin miscompares++;
            $display("FAIL bp_protocol: got %0d violations, want 0", v); end
        @(posedge clk); #2;
    endtask

    task automatic test_zero_nij();
        int dc, rd, nl, ne, v;
        num_nij_to_compute = 8'd0;
        start_mac_compute = 1'b1;
        run_pass(20, INST_EXEC, 64'h0, 0, -1, 0, dc, rd, nl, ne, v);
        vectors++; if (dc !== 2) begin miscompares++;
            $display("FAIL zero_done_cycle: got %0d, want 2", dc); end
        vectors++; if (rd !== 0 || ne !== 0) begin miscompares++;
            $display("FAIL zero_reads: got reads=%0d exec=%0d, want 0/0", rd, ne); end
        @(posedge clk); #2;
    endtask

    task automatic test_busy_start();
        int dc, rd, nl, ne, v;
        num_nij_to_compute = 8'd10;
        start_mac_compute = 1'b1;
        run_pass(80, INST_EXEC, 64'h0, 0, -1, 5, dc, rd, nl, ne, v);
        vectors++; if (dc !== 27) begin miscompares++;
            $display("FAIL busy_done_cycle: got %0d, want 27", dc); end
        vectors++; if (rd !== 10 || v !== 0) begin miscompares++;
            $display("FAIL busy_reads: got reads=%0d viol=%0d, want 10/0", rd, v); end
        vectors++; if ({error, kernel_loaded} !== 2'b11) begin miscompares++;
            $display("FAIL busy_error: got error/kl=%b, want 11", {error, kernel_loaded}); end
        @(posedge clk); #2;
    endtask

    task automatic test_reset_mid_compute();
        int done_seen;
        done_seen = 0;
        l0_o_ready = 1'b1;
        num_nij_to_compute = 8'd30;
        start_mac_compute = 1'b1;
        repeat (10) begin
            @(posedge clk); #1 start_mac_compute = 1'b0; #1;
        end
        vectors++; if (busy !== 1'b1 || inst_w !== INST_EXEC) begin miscompares++;
            $display("FAIL midrst_active: got busy=%b inst=%b, want 1/10", busy, inst_w); end
        reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0; #1;
        vectors++; if ({busy, kernel_loaded, error, done, l0_rd, inst_w} !== 7'b0) begin miscompares++;
            $display("FAIL midrst_state: got %b, want 0000000",
                     {busy, kernel_loaded, error, done, l0_rd, inst_w}); end
        repeat (25) begin
            @(posedge clk); #2;
            if (done || busy) done_seen++;
        end
        vectors++; if (done_seen !== 0) begin miscompares++;
            $display("FAIL midrst_no_done: got %0d active cycles, want 0", done_seen); end
    endtask

    task automatic test_both_starts();
        int dc, rd, nl, ne, v;
        start_kernel_load = 1'b1;
        start_mac_compute = 1'b1;
        num_nij_to_compute = 8'd5;
        run_pass(60, INST_LOAD, 64'h0, 0, -1, 0, dc, rd, nl, ne, v);
        vectors++; if (dc !== 25 || nl !== 8 || ne !== 0) begin miscompares++;
            $display("FAIL both_load_wins: got done=%0d load=%0d exec=%0d, want 25/8/0", dc, nl, ne); end
        vectors++; if (error !== 1'b1) begin miscompares++;
            $display("FAIL both_error: got %b, want 1", error); end
        @(posedge clk); #2;
    endtask

    task automatic test_done_edge_start();
        int dc, rd, nl, ne, v;
        do_reset(1);
        l0_o_ready = 1'b1;
        start_kernel_load = 1'b1;
        run_pass(60, INST_LOAD, 64'h0, 0, -1, 0, dc, rd, nl, ne, v);
        vectors++; if (dc !== 25 || error !== 1'b0) begin miscompares++;
            $display("FAIL doneedge_setup: got done=%0d error=%b, want 25/0", dc, error); end
        num_nij_to_compute = 8'd0;
        start_mac_compute = 1'b1;
        @(posedge clk); #1 start_mac_compute = 1'b0; #1;
        vectors++; if ({busy, error} !== 2'b01) begin miscompares++;
            $display("FAIL doneedge_ignored: got busy/error=%b, want 01", {busy, error}); end
        start_mac_compute = 1'b1;
        @(posedge clk); #1 start_mac_compute = 1'b0; #1;
        vectors++; if (busy !== 1'b1) begin miscompares++;
            $display("FAIL doneedge_accept: got busy=%b, want 1", busy); end
        repeat (3) begin @(posedge clk); #2; end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        reset = 1'b1;
        start_kernel_load = 1'b0;
        start_mac_compute = 1'b0;
        num_nij_to_compute = 8'd0;
        l0_o_ready = 1'b0;
        ofifo_almost_full = 1'b0;

        test_reset();
        test_compute_before_load();
        do_reset(2);
        l0_o_ready = 1'b1;
        test_load();
        test_compute();
        test_back_pressure();
        test_zero_nij();
        test_busy_start();
        test_reset_mid_compute();
        test_both_starts();
        test_done_edge_start();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
